icache_nway: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/icache_way.sv | 59 +++++
 rtl/icache_nway.sv | 198 +++++++++++++++++++
 tb/tb_icache_nway.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache FSM states, default cache geometry and derived-width helper.
package cpu_types_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned IBYT_W        = 2;
  localparam int unsigned ICACHE_WAYS   = 2;
  localparam int unsigned ICACHE_IIDX_W = 4;
  localparam int unsigned ICACHE_IBLK_W = 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  function automatic int unsigned icache_tag_w(input int unsigned iidx_w, input int unsigned iblk_w);
    return WORD_W - iidx_w - iblk_w - IBYT_W;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: valid/tag/data storage, combinational lookup,
// synchronous word write and single-cycle flush of all valid bits.
module icache_way
  import cpu_types_pkg::*;
#(
  parameter int unsigned IIDX_W = ICACHE_IIDX_W,
  parameter int unsigned IBLK_W = ICACHE_IBLK_W,
  parameter int unsigned TAG_W  = icache_tag_w(IIDX_W, IBLK_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [IIDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  input  logic [IBLK_W-1:0] rd_off,
  output logic              hit_c,
  output logic              vld_c,
  output logic [WORD_W-1:0] rdata_c,
  input  logic              wr_en,
  input  logic [IIDX_W-1:0] wr_idx,
  input  logic [IBLK_W-1:0] wr_off,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              set_vld,
  input  logic [TAG_W-1:0]  set_tag
);

  localparam int unsigned SETS = 2 ** IIDX_W;
  localparam int unsigned BLK  = 2 ** IBLK_W;

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [WORD_W-1:0] data_q [SETS][BLK];

  assign vld_c   = valid_q[rd_idx];
  assign hit_c   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rdata_c = data_q[rd_idx][rd_off];

  // Flush wins over a completing fill in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (set_vld) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; contents are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (set_vld) begin
      tag_q[wr_idx] <= set_tag;
    end
    if (wr_en) begin
      data_q[wr_idx][wr_off] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with multi-word block refill and flush.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_nway
  import cpu_types_pkg::*;
#(
  parameter int unsigned IWAYS  = ICACHE_WAYS,
  parameter int unsigned IIDX_W = ICACHE_IIDX_W,
  parameter int unsigned IBLK_W = ICACHE_IBLK_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  input  logic              iflush,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [WORD_W-1:0] hit_count,
  output logic [WORD_W-1:0] miss_count
`endif
);

  localparam int unsigned TAG_W   = icache_tag_w(IIDX_W, IBLK_W);
  localparam int unsigned SETS    = 2 ** IIDX_W;
  localparam int unsigned PTR_W   = (IWAYS > 1) ? $clog2(IWAYS) : 1;
  localparam int unsigned IDX_LSB = IBYT_W + IBLK_W;
  localparam int unsigned TAG_LSB = IDX_LSB + IIDX_W;

  icache_state_t     state_q, state_nxt;
  logic [TAG_W-1:0]  ftag_q, ftag_nxt;
  logic [IIDX_W-1:0] fidx_q, fidx_nxt;
  logic [IBLK_W-1:0] k_q, k_nxt;
  logic [PTR_W-1:0]  victim_q, victim_nxt;
  logic [PTR_W-1:0]  victim_sel;

  logic [TAG_W-1:0]  req_tag;
  logic [IIDX_W-1:0] req_idx;
  logic [IBLK_W-1:0] req_off;

  logic [IWAYS-1:0]  way_hit;
  logic [IWAYS-1:0]  way_vld;
  logic [WORD_W-1:0] way_data [IWAYS];
  logic              any_hit;
  logic [WORD_W-1:0] hit_data;
  logic              wr_en;
  logic              fill_done;

  assign req_tag = imemaddr[WORD_W-1 -: TAG_W];
  assign req_idx = imemaddr[TAG_LSB-1 -: IIDX_W];
  assign req_off = imemaddr[IDX_LSB-1 -: IBLK_W];

  wire unused_byte_off = ^imemaddr[IBYT_W-1:0];

  for (genvar w = 0; w < IWAYS; w++) begin : g_way
    icache_way #(
      .IIDX_W (IIDX_W),
      .IBLK_W (IBLK_W),
      .TAG_W  (TAG_W)
    ) u_way (
      .clk     (CLK),
      .rst_n   (nRST),
      .flush   (iflush),
      .rd_idx  (req_idx),
      .rd_tag  (req_tag),
      .rd_off  (req_off),
      .hit_c   (way_hit[w]),
      .vld_c   (way_vld[w]),
      .rdata_c (way_data[w]),
      .wr_en   (wr_en && (victim_q == PTR_W'(w))),
      .wr_idx  (fidx_q),
      .wr_off  (k_q),
      .wr_data (iload),
      .set_vld (fill_done && (victim_q == PTR_W'(w))),
      .set_tag (ftag_q)
    );
  end

  // At most one way matches, so OR-combining the gated words is the hit mux.
  always_comb begin
    any_hit  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < IWAYS; w++) begin
      if (way_hit[w]) begin
        any_hit  = 1'b1;
        hit_data = hit_data | way_data[w];
      end
    end
  end

  if (IWAYS > 1) begin : g_rr
    logic [PTR_W-1:0] ptr_q [SETS];

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
      end else if (iflush) begin
        for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
      end else if (fill_done) begin
        ptr_q[fidx_q] <= ptr_q[fidx_q] + PTR_W'(1);
      end
    end

    // Lowest-numbered invalid way, otherwise the set's round-robin pointer.
    always_comb begin
      victim_sel = ptr_q[req_idx];
      for (int w = IWAYS - 1; w >= 0; w--) begin
        if (!way_vld[w]) victim_sel = PTR_W'(w);
      end
    end
  end else begin : g_dm
    assign victim_sel = '0;
    wire unused_vld = &way_vld;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      ftag_q   <= '0;
      fidx_q   <= '0;
      k_q      <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_nxt;
      ftag_q   <= ftag_nxt;
      fidx_q   <= fidx_nxt;
      k_q      <= k_nxt;
      victim_q <= victim_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    ftag_nxt   = ftag_q;
    fidx_nxt   = fidx_q;
    k_nxt      = k_q;
    victim_nxt = victim_q;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    wr_en      = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!iflush && imemREN) begin
          if (any_hit) begin
            ihit     = 1'b1;
            imemload = hit_data;
          end else begin
            state_nxt  = FILL;
            ftag_nxt   = req_tag;
            fidx_nxt   = req_idx;
            k_nxt      = '0;
            victim_nxt = victim_sel;
          end
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = {ftag_q, fidx_q, k_q, IBYT_W'(0)};
        if (iflush) begin
          state_nxt = IDLE;
        end else if (!iwait) begin
          wr_en = 1'b1;
          k_nxt = IBLK_W'(k_q + IBLK_W'(1));
          if (k_q == '1) begin
            fill_done = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ICACHE_STATS_EN
  // Saturating counters; only nRST clears them.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && (hit_count != '1)) begin
        hit_count <= hit_count + WORD_W'(1);
      end
      if ((state_q == IDLE) && (state_nxt == FILL) && (miss_count != '1)) begin
        miss_count <= miss_count + WORD_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Self-checking bench for icache_nway: directed scenarios then random accesses against a set/way model.
module tb_icache_nway;

  localparam int unsigned IWAYS  = 2;
  localparam int unsigned IIDX_W = 4;
  localparam int unsigned IBLK_W = 1;
  localparam int unsigned SETS   = 1 << IIDX_W;
  localparam int unsigned BLK    = 1 << IBLK_W;
  localparam int unsigned IDX_SH = 2 + IBLK_W;
  localparam int unsigned TAG_SH = IDX_SH + IIDX_W;

  logic        CLK = 1'b0;
  logic        nRST, imemREN, ihit, iflush, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int rsp_cnt = 0;
  int cyc;
  logic [31:0] ra;

  bit          m_vld [IWAYS][SETS];
  int unsigned m_tag [IWAYS][SETS];
  int unsigned m_ptr [SETS];
  int unsigned m_hits = 0;
  int unsigned m_misses = 0;

  icache_nway #(.IWAYS(IWAYS), .IIDX_W(IIDX_W), .IBLK_W(IBLK_W)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iflush   (iflush),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int unsigned f_idx(input logic [31:0] a);
    return (a >> IDX_SH) % SETS;
  endfunction

  function automatic int unsigned f_tag(input logic [31:0] a);
    return a >> TAG_SH;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    for (int w = 0; w < IWAYS; w++)
      if (m_vld[w][f_idx(a)] && m_tag[w][f_idx(a)] == f_tag(a)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_fill(input logic [31:0] a);
    int unsigned s = f_idx(a);
    int v = -1;
    for (int w = 0; w < IWAYS; w++)
      if (!m_vld[w][s] && v < 0) v = w;
    if (v < 0) v = int'(m_ptr[s]);
    m_vld[v][s] = 1'b1;
    m_tag[v][s] = f_tag(a);
    m_ptr[s] = (m_ptr[s] + 1) % IWAYS;
    m_misses++;
  endtask

  task automatic m_flush();
    for (int w = 0; w < IWAYS; w++)
      for (int s = 0; s < SETS; s++) m_vld[w][s] = 1'b0;
    for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats();
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
`endif
  endtask

  // Memory: lat busy cycles, then one cycle with iwait low and the word for iaddr.
  initial begin
    iwait = 1'b1;
    iload = '0;
    forever begin
      @(posedge CLK); #1;
      if (iREN === 1'b1) begin
        if (rsp_cnt < lat) begin
          iwait = 1'b1;
          rsp_cnt++;
        end else begin
          iwait = 1'b0;
          iload = mem_word(iaddr);
          rsp_cnt = 0;
        end
      end else begin
        iwait = 1'b1;
        rsp_cnt = 0;
      end
    end
  end

  // Called just after the edge that entered FILL; returns just after the edge back to IDLE.
  task automatic run_fill(input logic [31:0] a, output int ncyc);
    logic [31:0] base = a & ~((32'd1 << IDX_SH) - 32'd1);
    int unsigned k = 0;
    ncyc = 0;
    while (k < BLK && ncyc < 100) begin
      @(negedge CLK);
      ncyc++;
      chk("fill_ihit", ihit, 0);
      if (iREN === 1'b1 && iwait === 1'b0) begin
        chk("fill_iaddr", iaddr, base + 4 * k);
        k++;
      end
    end
    chk("fill_words", k, BLK);
    m_fill(a);
    @(posedge CLK); #1;
  endtask

  task automatic access(input logic [31:0] a);
    int ncyc;
    bit exp_hit = m_hit(a);
    imemaddr = a;
    imemREN  = 1'b1;
    @(negedge CLK);
    chk("ihit", ihit, exp_hit);
    if (exp_hit) begin
      chk("hit_data", imemload, mem_word(a));
      chk("hit_iREN", iREN, 0);
      m_hits++;
      @(posedge CLK); #1;
    end else begin
      @(posedge CLK); #1;
      run_fill(a, ncyc);
      chk("fill_cycles", ncyc, BLK * (lat + 1));
      @(negedge CLK);
      chk("ret_iREN", iREN, 0);
      chk("ret_ihit", ihit, 1);
      chk("ret_data", imemload, mem_word(a));
      m_hits++;
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h40; iflush = 1'b0;
    m_flush();
    #12;
    chk("rst_ihit", ihit, 0);
    chk("rst_iREN", iREN, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_imemload", imemload, 0);
    chk_stats();
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;

    // Cold miss then neighbouring word of the same block
    lat = 2;
    access(32'h40);
    access(32'h44);

    // Conflicts in set 8
    access(32'h840);
    access(32'h1040);
    access(32'h840);
    access(32'h40);
    chk_stats();

    // Flush during the second word of a fill
    imemaddr = 32'h300; imemREN = 1'b1;
    @(negedge CLK); chk("fl_miss", ihit, 0);
    @(posedge CLK); #1;
    repeat (3) @(posedge CLK);
    #1;
    chk("fl_word1_iaddr", iaddr, 32'h304);
    iflush = 1'b1; imemREN = 1'b0;
    @(negedge CLK);
    chk("fl_iREN_hold", iREN, 1);
    chk("fl_ihit", ihit, 0);
    @(posedge CLK); #1;
    iflush = 1'b0;
    m_flush();
    m_misses++;
    @(negedge CLK); chk("fl_iREN_drop", iREN, 0);
    @(posedge CLK); #1;
    chk_stats();
    access(32'h44);
    access(32'h840);

    // Flush in a would-be hit cycle forces ihit low
    imemaddr = 32'h44; imemREN = 1'b1; iflush = 1'b1;
    @(negedge CLK);
    chk("flhit_ihit", ihit, 0);
    chk("flhit_data", imemload, 0);
    @(posedge CLK); #1;
    iflush = 1'b0; imemREN = 1'b0;
    m_flush();
    chk_stats();

    // Reset asserted mid-fill
    imemaddr = 32'h500; imemREN = 1'b1;
    @(negedge CLK); chk("rm_miss", ihit, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #3;
    chk("rm_iREN_pre", iREN, 1);
    nRST = 1'b0; imemREN = 1'b0;
    #1;
    chk("rm_iREN", iREN, 0);
    chk("rm_ihit", ihit, 0);
    chk("rm_iaddr", iaddr, 0);
    m_flush(); m_hits = 0; m_misses = 0;
    chk_stats();
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;

    // Address change mid-fill does not abort the fill
    imemaddr = 32'h40; imemREN = 1'b1;
    @(negedge CLK); chk("sw_miss", ihit, 0);
    @(posedge CLK); #1;
    imemaddr = 32'h200;
    run_fill(32'h40, cyc);
    chk("sw_fill_cycles", cyc, BLK * (lat + 1));
    access(32'h200);
    access(32'h44);
    chk_stats();

    // Random accesses over a small address pool with occasional flushes
    for (int n = 0; n < 60; n++) begin
      ra = ($urandom_range(0, 3) << TAG_SH) | ($urandom_range(0, 3) << IDX_SH) |
           ($urandom_range(0, BLK - 1) << 2);
      lat = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) begin
        imemaddr = ra; imemREN = 1'b1; iflush = 1'b1;
        @(negedge CLK); chk("rnd_flush_ihit", ihit, 0);
        @(posedge CLK); #1;
        iflush = 1'b0; imemREN = 1'b0;
        m_flush();
      end else begin
        access(ra);
      end
    end
    chk_stats();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
